// File: rtl/iir_pkg.sv
// iir_pkg: shared types and constants for the iir_cascade engine.
package iir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

    // Coefficient slot order inside one section; also the MAC product order.
    localparam logic [2:0] K_B0 = 3'd0;
    localparam logic [2:0] K_B1 = 3'd1;
    localparam logic [2:0] K_B2 = 3'd2;
    localparam logic [2:0] K_A1 = 3'd3;
    localparam logic [2:0] K_A2 = 3'd4;
    localparam int         NUM_K = 5;

    localparam logic [5:0] REG_CLIP  = 6'd61;
    localparam logic [5:0] REG_CLEAR = 6'd62;
    localparam logic [5:0] REG_COUNT = 6'd63;

    // Config address of coefficient k in section s.
    function automatic logic [5:0] coeff_addr(input int s, input int k);
        return 6'(NUM_K * s + k);
    endfunction

endpackage

// File: rtl/iir_cascade_if.sv
// iir_cascade_if: sample stream in/out plus the Avalon-style config slave.
interface iir_cascade_if #(parameter int DATA_W = 32);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     cfg_write;
    logic [5:0]               cfg_address;
    logic [31:0]              cfg_writedata;
    logic                     cfg_read;
    logic [31:0]              cfg_readdata;
    logic                     cfg_waitrequest;

    modport slave (
        input  in_data, in_valid, out_ready,
        input  cfg_write, cfg_address, cfg_writedata, cfg_read,
        output in_ready, out_data, out_valid, cfg_readdata, cfg_waitrequest
    );

    modport master (
        output in_data, in_valid, out_ready,
        output cfg_write, cfg_address, cfg_writedata, cfg_read,
        input  in_ready, out_data, out_valid, cfg_readdata, cfg_waitrequest
    );
endinterface

// File: rtl/iir_mac.sv
// iir_mac: signed coefficient x sample product, sign-extended and accumulated.
module iir_mac #(
    parameter int COEFF_W = 16,
    parameter int DATA_W  = 32,
    parameter int ACC_W   = DATA_W + COEFF_W + 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic                      neg_i,
    input  logic signed [COEFF_W-1:0] coef_i,
    input  logic signed [DATA_W-1:0]  data_i,
    output logic signed [ACC_W-1:0]   acc_o
);
    localparam int PW = COEFF_W + DATA_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] term, acc_d, acc_q;

    // Product, optional negation, and restart-or-accumulate select.
    always_comb begin
        prod  = PW'(coef_i) * PW'(data_i);
        term  = ACC_W'(prod);
        if (neg_i) term = -term;
        acc_d = (clr_i ? '0 : acc_q) + term;
    end

    // Accumulator register, advanced only while the engine is in MAC.
    always_ff @(posedge clk) begin
        if (!rst_n)    acc_q <= '0;
        else if (en_i) acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/iir_cascade.sv
// iir_cascade: NUM_SECTIONS direct-form-I biquads sharing one MAC.
// Optional macro IIR_SATURATE_EN: clamp on narrowing and count clips (reg 61).
module iir_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int COEFF_W      = 16,
    parameter int COEFF_FRAC   = 14,
    parameter int NUM_SECTIONS = 2,
    parameter int ACC_W        = DATA_W + COEFF_W + 3
) (
    input  logic          clk,
    input  logic          reset_n,
    iir_cascade_if.slave  bus
);
    localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam logic [SW-1:0] LAST_S = SW'(NUM_SECTIONS - 1);

    typedef logic signed [DATA_W-1:0]  samp_t;
    typedef logic signed [COEFF_W-1:0] coef_t;

    localparam coef_t ONE = coef_t'(2 ** COEFF_FRAC);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (COEFF_FRAC - 1));

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    k_q, k_d;

    coef_t coef_q [NUM_SECTIONS][NUM_K];
    samp_t x1_q [NUM_SECTIONS];
    samp_t x2_q [NUM_SECTIONS];
    samp_t y1_q [NUM_SECTIONS];
    samp_t y2_q [NUM_SECTIONS];
    samp_t xin_q, out_data_q, mac_data, y_nar;
    coef_t mac_coef;
    logic  mac_neg, in_ready_q;
    logic [31:0] cnt_q, rdata_q, rdata_d;
    logic signed [ACC_W-1:0] acc, rnd, yfull;
`ifdef IIR_SATURATE_EN
    logic        clip;
    logic [31:0] clip_cnt_q;
`endif
    logic unused_bits;

    // Sequencer state: section index s and product index k.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= K_B0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    // Next-state: accept, five products per section, scale, then hold output.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: if (bus.in_valid && in_ready_q) begin
                state_d = MAC;
                s_d     = '0;
                k_d     = K_B0;
            end
            MAC: if (k_q == K_A2) state_d = SCALE;
                 else             k_d     = k_q + 3'd1;
            SCALE: if (s_q == LAST_S) state_d = OUT;
                   else begin
                       state_d = MAC;
                       s_d     = s_q + SW'(1);
                       k_d     = K_B0;
                   end
            OUT: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand select; feedback terms are subtracted (stored a1/a2 are negated).
    always_comb begin
        mac_coef = coef_q[s_q][k_q];
        mac_neg  = (k_q == K_A1) || (k_q == K_A2);
        case (k_q)
            K_B0:    mac_data = xin_q;
            K_B1:    mac_data = x1_q[s_q];
            K_B2:    mac_data = x2_q[s_q];
            K_A1:    mac_data = y1_q[s_q];
            default: mac_data = y2_q[s_q];
        endcase
    end

    iir_mac #(.COEFF_W(COEFF_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst_n  (reset_n),
        .en_i   (state_q == MAC),
        .clr_i  (k_q == K_B0),
        .neg_i  (mac_neg),
        .coef_i (mac_coef),
        .data_i (mac_data),
        .acc_o  (acc)
    );

    // Round-half-up rescale, then narrow to the sample width.
    always_comb begin
        rnd   = acc + HALF;
        yfull = rnd >>> COEFF_FRAC;
        y_nar = yfull[DATA_W-1:0];
`ifdef IIR_SATURATE_EN
        clip = 1'b0;
        if (yfull > ACC_W'(samp_t'({1'b0, {(DATA_W-1){1'b1}}}))) begin
            y_nar = {1'b0, {(DATA_W-1){1'b1}}};
            clip  = 1'b1;
        end else if (yfull < ACC_W'(samp_t'({1'b1, {(DATA_W-1){1'b0}}}))) begin
            y_nar = {1'b1, {(DATA_W-1){1'b0}}};
            clip  = 1'b1;
        end
`endif
    end

    // Config read mux; coefficients read back sign-extended.
    always_comb begin
        rdata_d = '0;
        for (int s = 0; s < NUM_SECTIONS; s++)
            for (int k = 0; k < NUM_K; k++)
                if (bus.cfg_address == coeff_addr(s, k)) rdata_d = 32'(coef_q[s][k]);
        if (bus.cfg_address == REG_COUNT) rdata_d = cnt_q;
`ifdef IIR_SATURATE_EN
        if (bus.cfg_address == REG_CLIP)  rdata_d = clip_cnt_q;
`endif
    end

    // Datapath: config writes in IDLE, sample latch, section history update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            xin_q      <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            in_ready_q <= 1'b0;
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
                for (int k = 0; k < NUM_K; k++)
                    coef_q[s][k] <= (k == 0) ? ONE : '0;
            end
        end else begin
            in_ready_q <= (state_d == IDLE);
            if (bus.cfg_read) rdata_q <= rdata_d;
            if (state_q == IDLE) begin
                if (bus.cfg_write) begin
                    for (int s = 0; s < NUM_SECTIONS; s++)
                        for (int k = 0; k < NUM_K; k++)
                            if (bus.cfg_address == coeff_addr(s, k))
                                coef_q[s][k] <= bus.cfg_writedata[COEFF_W-1:0];
                    if (bus.cfg_address == REG_CLEAR)
                        for (int s = 0; s < NUM_SECTIONS; s++) begin
                            x1_q[s] <= '0;
                            x2_q[s] <= '0;
                            y1_q[s] <= '0;
                            y2_q[s] <= '0;
                        end
                end
                if (bus.in_valid && in_ready_q) xin_q <= bus.in_data;
            end
            if (state_q == SCALE) begin
                x2_q[s_q] <= x1_q[s_q];
                x1_q[s_q] <= xin_q;
                y2_q[s_q] <= y1_q[s_q];
                y1_q[s_q] <= y_nar;
                xin_q     <= y_nar;
                if (s_q == LAST_S) out_data_q <= y_nar;
            end
            if (state_q == OUT && bus.out_ready) cnt_q <= cnt_q + 32'd1;
        end
    end

`ifdef IIR_SATURATE_EN
    // Sticky count of scale steps whose result had to be clamped.
    always_ff @(posedge clk) begin
        if (!reset_n)                      clip_cnt_q <= '0;
        else if (state_q == SCALE && clip) clip_cnt_q <= clip_cnt_q + 32'd1;
    end
`endif

    assign unused_bits         = ^{bus.cfg_writedata[31:COEFF_W], yfull[ACC_W-1:DATA_W]};
    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = (state_q == OUT);
    assign bus.out_data        = out_data_q;
    assign bus.cfg_readdata    = rdata_q;
    assign bus.cfg_waitrequest = (state_q != IDLE);
endmodule

// File: tb/tb_iir_cascade.sv
// tb_iir_cascade: directed vectors for iir_cascade at default parameters.
module tb_iir_cascade;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] y;
    int          lat;
    int          bad;

    iir_cascade_if #(.DATA_W(32)) bus();

    iir_cascade dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        checks++;
        failures++;
        $display("FAIL %s wait expired", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [5:0] a, input logic [31:0] d);
        int n = 0;
        while (bus.cfg_waitrequest && n < 100) begin tick(); n++; end
        if (n >= 100) expire("cfg_wr");
        bus.cfg_address   = a;
        bus.cfg_writedata = d;
        bus.cfg_write     = 1'b1;
        tick();
        bus.cfg_write     = 1'b0;
    endtask

    task automatic cfg_rd(input logic [5:0] a, output logic [31:0] d);
        bus.cfg_address = a;
        bus.cfg_read    = 1'b1;
        tick();
        bus.cfg_read    = 1'b0;
        d = bus.cfg_readdata;
    endtask

    task automatic push(input logic [31:0] x);
        int n = 0;
        while (!bus.in_ready && n < 100) begin tick(); n++; end
        if (n >= 100) expire("in_ready");
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // lat = cycles from the handshake cycle to the first out_valid cycle.
    task automatic wait_out(output int l);
        l = 1;
        while (!bus.out_valid && l < 100) begin tick(); l++; end
        if (!bus.out_valid) expire("out_valid");
    endtask

    task automatic pop(output logic [31:0] d);
        d = bus.out_data;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic send_chk(input string tag, input logic [31:0] x, input logic [31:0] exp);
        int l;
        logic [31:0] d;
        push(x);
        wait_out(l);
        pop(d);
        chk(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.cfg_write = 1'b0; bus.cfg_read = 1'b0;
        bus.cfg_address = '0; bus.cfg_writedata = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_waitreq", 32'(bus.cfg_waitrequest), 0);
        chk("rst_readdata", bus.cfg_readdata, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        cfg_rd(6'd0, y);  chk("rd_b0_ident", y, 32'h0000_4000);
        cfg_rd(6'd3, y);  chk("rd_a1_ident", y, 0);
        cfg_rd(6'd20, y); chk("rd_unmapped", y, 0);
        cfg_rd(6'd61, y); chk("rd_clip_init", y, 0);

        // Identity cascade
        push(32'd1000);
        wait_out(lat);
        chk("latency", 32'(lat), 13);
        pop(y);
        chk("ident_1000", y, 32'd1000);
        send_chk("ident_neg5", 32'hFFFF_FFFB, 32'hFFFF_FFFB);
        cfg_rd(6'd63, y); chk("count_2", y, 2);

        // Half gain, round half up
        cfg_wr(6'd0, 32'd8192);
        send_chk("half_1000", 32'd1000, 32'd500);
        send_chk("half_3", 32'd3, 32'd2);

        // y = x + 0.5*y1 impulse response
        cfg_wr(6'd0, 32'd16384);
        cfg_wr(6'd3, 32'hFFFF_E000);
        cfg_wr(6'd62, 32'd0);
        cfg_rd(6'd3, y); chk("rd_a1_neg", y, 32'hFFFF_E000);
        send_chk("imp_0", 32'd16384, 32'd16384);
        send_chk("imp_1", 32'd0, 32'd8192);
        send_chk("imp_2", 32'd0, 32'd4096);
        send_chk("imp_3", 32'd0, 32'd2048);
        cfg_wr(6'd62, 32'd0);
        send_chk("after_clear", 32'd0, 32'd0);

        // Backpressure
        push(32'd100);
        wait_out(lat);
        chk("bp_data", bus.out_data, 32'd100);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_data !== 32'd100 || bus.in_ready !== 1'b0 ||
                bus.cfg_waitrequest !== 1'b1 || bus.out_valid !== 1'b1) bad++;
            tick();
        end
        chk("bp_hold", 32'(bad), 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_valid_drop", 32'(bus.out_valid), 0);
        chk("bp_in_ready", 32'(bus.in_ready), 1);
        cfg_rd(6'd63, y); chk("count_10", y, 10);

        // Write and sample in the same cycle: new b0 = 0.5, y1 = 100
        bus.cfg_address = 6'd0; bus.cfg_writedata = 32'd8192; bus.cfg_write = 1'b1;
        bus.in_data = 32'd200;  bus.in_valid = 1'b1;
        tick();
        bus.cfg_write = 1'b0; bus.in_valid = 1'b0;
        wait_out(lat);
        pop(y);
        chk("same_cycle_wr", y, 32'd150);

        // Overflow on narrowing
        cfg_wr(6'd0, 32'd32767);
        cfg_wr(6'd3, 32'd0);
        cfg_wr(6'd62, 32'd0);
`ifdef IIR_SATURATE_EN
        send_chk("sat_out", 32'h7FFF_0000, 32'h7FFF_FFFF);
        cfg_rd(6'd61, y); chk("clip_count", y, 1);
`else
        send_chk("wrap_out", 32'h7FFF_0000, 32'hFFFC_0004);
        cfg_rd(6'd61, y); chk("clip_reg_zero", y, 0);
`endif

        // Reset during section 1 MAC
        push(32'd5);
        repeat (8) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b0) bad++;
            tick();
        end
        chk("abort_no_out", 32'(bad), 0);
        cfg_rd(6'd0, y);  chk("abort_b0_ident", y, 32'h0000_4000);
        cfg_rd(6'd63, y); chk("abort_count", y, 0);
        send_chk("abort_ident_7", 32'd7, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
